// File: rtl/button_conditioner.sv
// Push-button front end: per-channel synchroniser, stable-count debounce, clean level plus press/release pulses.
// Define BTN_AUTOREPEAT_EN to add held-button auto-repeat press pulses.
module button_conditioner #(
   parameter int N_BTN           = 3,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int ACTIVE_LOW      = 1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [N_BTN-1:0] POL_MASK = (ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("button_conditioner: invalid parameter value");
   end

   typedef enum logic [1:0] {RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE} state_t;

   logic [N_BTN-1:0]                  p;
   logic [N_BTN-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
   state_t                            state_q [N_BTN];
   state_t                            state_d [N_BTN];
   logic [CNT_W-1:0]                  cnt_q   [N_BTN];
   logic [CNT_W-1:0]                  cnt_d   [N_BTN];
   logic [N_BTN-1:0]                  level_q, level_d;
   logic [N_BTN-1:0]                  press_q, press_d;
   logic [N_BTN-1:0]                  release_q, release_d;

`ifdef BTN_AUTOREPEAT_EN
   localparam int               RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int               RPT_W     = $clog2(RPT_MAX + 1);
   localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
   localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD);

   logic [RPT_W-1:0] rpt_q [N_BTN];
   logic [RPT_W-1:0] rpt_d [N_BTN];
   logic [RPT_W-1:0] rpt_inc;
   logic [N_BTN-1:0] armed_q, armed_d;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   assign p = btn_raw ^ POL_MASK;

   always_comb begin
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
`ifdef BTN_AUTOREPEAT_EN
      armed_d   = armed_q;
      rpt_inc   = '0;
`endif
      for (int i = 0; i < N_BTN; i++) begin
         sync_d[i]  = {sync_q[i][SYNC_STAGES-2:0], p[i]};
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            RELEASED: begin
               if (sync_q[i][SYNC_STAGES-1]) begin
                  state_d[i] = CONFIRM_PRESS;
                  cnt_d[i]   = CNT_W'(1);
               end else begin
                  cnt_d[i]   = '0;
               end
            end
            CONFIRM_PRESS: begin
               if (!sync_q[i][SYNC_STAGES-1]) begin
                  state_d[i] = RELEASED;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_MAX) begin
                  state_d[i] = PRESSED;
                  cnt_d[i]   = '0;
                  level_d[i] = 1'b1;
                  press_d[i] = 1'b1;
               end else begin
                  cnt_d[i]   = sat_inc(cnt_q[i]);
               end
            end
            PRESSED: begin
               if (!sync_q[i][SYNC_STAGES-1]) begin
                  state_d[i] = CONFIRM_RELEASE;
                  cnt_d[i]   = CNT_W'(1);
               end
            end
            CONFIRM_RELEASE: begin
               if (sync_q[i][SYNC_STAGES-1]) begin
                  state_d[i]   = PRESSED;
                  cnt_d[i]     = '0;
               end else if (cnt_q[i] == CNT_MAX) begin
                  state_d[i]   = RELEASED;
                  cnt_d[i]     = '0;
                  level_d[i]   = 1'b0;
                  release_d[i] = 1'b1;
               end else begin
                  cnt_d[i]     = sat_inc(cnt_q[i]);
               end
            end
            default: begin
               state_d[i] = RELEASED;
               cnt_d[i]   = '0;
            end
         endcase
`ifdef BTN_AUTOREPEAT_EN
         // Repeat timer runs only while stably pressed; confirm-release holds it, released/confirm-press clear it.
         rpt_d[i] = rpt_q[i];
         if (state_q[i] == PRESSED) begin
            rpt_inc = rpt_q[i] + 1'b1;
            if (rpt_inc == (armed_q[i] ? RPT_NEXT : RPT_FIRST)) begin
               press_d[i] = 1'b1;
               rpt_d[i]   = '0;
               armed_d[i] = 1'b1;
            end else begin
               rpt_d[i]   = rpt_inc;
            end
         end else if (state_q[i] != CONFIRM_RELEASE) begin
            rpt_d[i]   = '0;
            armed_d[i] = 1'b0;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            state_q[i] <= RELEASED;
            cnt_q[i]   <= '0;
         end
`ifdef BTN_AUTOREPEAT_EN
         armed_q <= '0;
         for (int i = 0; i < N_BTN; i++) rpt_q[i] <= '0;
`endif
      end else begin
         sync_q    <= sync_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         for (int i = 0; i < N_BTN; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
`ifdef BTN_AUTOREPEAT_EN
         armed_q <= armed_d;
         for (int i = 0; i < N_BTN; i++) rpt_q[i] <= rpt_d[i];
`endif
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: run-length debounce model compared every cycle, plus literal timing checks.
module tb_button_conditioner;

   localparam int N  = 3;
   localparam int SS = 2;
   localparam int DB = 4;
   localparam int AL = 1;
   localparam int RD = 10;
   localparam int RP = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] btn_raw = '1;
   logic [N-1:0] btn_level, btn_press, btn_release;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   button_conditioner #(
      .N_BTN(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(AL),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .rst(rst), .btn_raw(btn_raw),
      .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
   );

   always #5 clk = ~clk;

   // Model: s lags p by SS edges; a level flips once s has disagreed with it on DB+1 consecutive edges.
   bit p_hist [N][$];
   bit m_level [N];
   bit m_press [N];
   bit m_rel   [N];
   int m_run   [N];
   int m_act   [N];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < N; c++) begin
            p_hist[c].delete();
            for (int k = 0; k < SS; k++) p_hist[c].push_back(1'b0);
            m_level[c] = 0; m_press[c] = 0; m_rel[c] = 0; m_run[c] = 0; m_act[c] = 0;
         end
      end else begin
         for (int c = 0; c < N; c++) begin
            bit s;
            s = p_hist[c].pop_front();
            p_hist[c].push_back(btn_raw[c] ^ AL[0]);
            m_press[c] = 0;
            m_rel[c]   = 0;
`ifdef BTN_AUTOREPEAT_EN
            if (m_level[c] && m_run[c] == 0) begin
               m_act[c]++;
               if (m_act[c] >= RD && (m_act[c] - RD) % RP == 0) m_press[c] = 1;
            end
`endif
            if (s != m_level[c]) begin
               m_run[c]++;
               if (m_run[c] == DB + 1) begin
                  m_level[c] = s;
                  m_run[c]   = 0;
                  m_act[c]   = 0;
                  if (s) m_press[c] = 1;
                  else   m_rel[c]   = 1;
               end
            end else begin
               m_run[c] = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [3*N-1:0] exp_v, act_v;
         for (int c = 0; c < N; c++) begin
            exp_v[c]       = m_level[c];
            exp_v[N + c]   = m_press[c];
            exp_v[2*N + c] = m_rel[c];
         end
         act_v = {btn_release, btn_press, btn_level};
         tests++;
         if (act_v !== exp_v) begin
            fails++;
            $display("FAIL model t=%0t {rel,press,level} got %b expected %b", $time, act_v, exp_v);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   // Drive a press (or release) on the masked channels and pin the pulse to edge E0+SS+DB (k==7).
   task automatic edge_check(input logic [N-1:0] mask, input bit press, input string name);
      @(posedge clk); #2;
      for (int c = 0; c < N; c++) if (mask[c]) btn_raw[c] = press ? 1'b0 : 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk); @(negedge clk);
         if (press) begin
            check({name, "_press"}, btn_press, (k == 7) ? mask : '0);
            check({name, "_level"}, btn_level & mask, (k >= 7) ? mask : '0);
         end else begin
            check({name, "_release"}, btn_release, (k == 7) ? mask : '0);
            check({name, "_level"}, btn_level & mask, (k >= 7) ? '0 : mask);
         end
      end
   endtask

   function automatic bit rpt_exp(input int rel);
      if (rel < 0) return 1'b0;
      if (rel == 0) return 1'b1;
`ifdef BTN_AUTOREPEAT_EN
      return (rel >= RD) && ((rel - RD) % RP == 0);
`else
      return 1'b0;
`endif
   endfunction

   int hold [N];
   int rst_left;

   initial begin
      @(posedge clk); #2;
      chk_en = 1'b1;
      // Reset held with all buttons released, then idle
      cycles(9); #2;
      check("in_reset", {btn_level, btn_press, btn_release}, '0);
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("idle", {btn_level, btn_press, btn_release}, '0);
      end

      // Single press / release on channel 0
      edge_check(3'b001, 1'b1, "ch0");
      cycles(2);
      edge_check(3'b001, 1'b0, "ch0");
      cycles(4);

      // Bounce on channel 1 never qualifies
      @(posedge clk); #2 btn_raw[1] = 1'b0;
      @(posedge clk); @(posedge clk); #2 btn_raw[1] = 1'b1;
      @(posedge clk); #2 btn_raw[1] = 1'b0;
      @(posedge clk); @(posedge clk); #2 btn_raw[1] = 1'b1;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         check("bounce_press", btn_press[1], 1'b0);
         check("bounce_level", btn_level[1], 1'b0);
      end

      // Reset mid-press on channel 2, then re-qualification
      edge_check(3'b100, 1'b1, "ch2");
      @(posedge clk); #2 rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("midrst", {btn_level, btn_press, btn_release}, '0);
         @(posedge clk); #2;
      end
      rst = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); @(negedge clk);
         check("requal_press", btn_press, (k == 7) ? 3'b100 : 3'b000);
      end
      edge_check(3'b100, 1'b0, "ch2");
      cycles(4);

      // Coincident presses on channels 0 and 2
      edge_check(3'b101, 1'b1, "ch02");
      edge_check(3'b101, 1'b0, "ch02");
      cycles(4);

      // Long hold on channel 0: repeat schedule relative to acceptance
      @(posedge clk); #2 btn_raw[0] = 1'b0;
      for (int k = 1; k <= 38; k++) begin
         @(posedge clk); @(negedge clk);
         check("hold_press", btn_press[0], rpt_exp(k - 7));
      end
      @(posedge clk); #2 btn_raw[0] = 1'b1;
      cycles(12);

      // Random toggling with bounces, long holds and occasional resets
      for (int c = 0; c < N; c++) hold[c] = 0;
      rst_left = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #2;
         if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) rst = 1'b0;
         end else if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            rst_left = $urandom_range(1, 3);
         end
         for (int c = 0; c < N; c++) begin
            if (hold[c] == 0) begin
               btn_raw[c] = ~btn_raw[c];
               hold[c] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4) : $urandom_range(6, 40);
            end else begin
               hold[c]--;
            end
         end
      end
      rst = 1'b0;
      btn_raw = '1;
      cycles(15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
